// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES-128 encryption-core scheduler.
//   AES_W    : AES block and key width
//   GNT_W    : width of the requester index (supports up to 8 requesters)
//   state_e  : scheduler FSM states
//   timer_w  : width of a counter that has to hold 0..timeout
package aes_sched_pkg;

    localparam int unsigned AES_W = 128;
    localparam int unsigned GNT_W = 3;

    typedef enum logic [2:0] {
        StIdle,
        StKload,
        StKwait,
        StDstart,
        StDbusy,
        StDone
    } state_e;

    function automatic int unsigned timer_w(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The winner is the first requester after the pointer, wrapping around.
// Ports:
//   req     : request vector, one bit per requester
//   ptr     : index of the previous winner
//   gnt     : one-hot grant (all zero when nobody requests)
//   gnt_idx : index of the granted requester
//   gnt_vld : at least one requester was granted
module rr_arbiter
    import aes_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [GNT_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [GNT_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    int cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        // Walk the requesters in priority order, starting just after ptr.
        for (int off = 1; off <= int'(NREQ); off++) begin
            cand = int'(ptr) + off;
            if (cand >= int'(NREQ)) begin
                cand = cand - int'(NREQ);
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!gnt_vld && req[i] && (i == cand)) begin
                    gnt_vld = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = GNT_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/aes_enc_scheduler.sv
// Shares one iterative AES-128 encryption core among NREQ requesters.
// Jobs are served one at a time in round-robin order. The core key register
// is only reloaded when the granted key differs from the cached one.
// Ports:
//   CLK, RSTn          : clock, asynchronous active-low reset
//   Req/Kreq/Dreq      : per-requester level request, key and plaintext
//   KFlush             : pulse, invalidates the key cache
//   Ack/Dout           : one-hot completion pulse with registered ciphertext
//   Err                : pulse, job aborted after TIMEOUT busy cycles
//   Gnt_id/Busy        : requester being served, scheduler not idle
//   Aes_*              : handshake and data towards/from the AES core
module aes_enc_scheduler
    import aes_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*AES_W-1:0] Kreq,
    input  logic [NREQ*AES_W-1:0] Dreq,
    input  logic                  KFlush,
    output logic [NREQ-1:0]       Ack,
    output logic [AES_W-1:0]      Dout,
    output logic                  Err,
    output logic [GNT_W-1:0]      Gnt_id,
    output logic                  Busy,
    output logic [AES_W-1:0]      Aes_Kin,
    output logic [AES_W-1:0]      Aes_Din,
    output logic                  Aes_Krdy,
    output logic                  Aes_Drdy,
    output logic                  Aes_EN,
    input  logic [AES_W-1:0]      Aes_Dout,
    input  logic                  Aes_BSY,
    input  logic                  Aes_Dvld
);

    localparam int unsigned TW = timer_w(TIMEOUT);

    state_e             state;
    logic [GNT_W-1:0]   rr_ptr;
    logic [AES_W-1:0]   key_cache;
    logic               key_vld;
    logic               bsy_seen;
    logic [TW-1:0]      timer;

    logic [NREQ-1:0]    gnt;
    logic [GNT_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic [AES_W-1:0]   sel_key;
    logic [AES_W-1:0]   sel_pt;
    logic               key_hit;
    logic               job_done;
    logic               timeout_hit;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req     (Req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        sel_key = '0;
        sel_pt  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                sel_key = Kreq[i*AES_W +: AES_W];
                sel_pt  = Dreq[i*AES_W +: AES_W];
            end
        end
    end

    assign key_hit     = key_vld && (key_cache == sel_key);
    // Dvld is a level from the previous job until the core goes busy, so only
    // trust it after BSY has been observed for this job.
    assign job_done    = bsy_seen && !Aes_BSY && Aes_Dvld;
    assign timeout_hit = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= StIdle;
            rr_ptr    <= GNT_W'(NREQ - 1);
            key_cache <= '0;
            key_vld   <= 1'b0;
            bsy_seen  <= 1'b0;
            timer     <= '0;
            Ack       <= '0;
            Dout      <= '0;
            Err       <= 1'b0;
            Gnt_id    <= '0;
            Busy      <= 1'b0;
            Aes_Kin   <= '0;
            Aes_Din   <= '0;
            Aes_Krdy  <= 1'b0;
            Aes_Drdy  <= 1'b0;
            Aes_EN    <= 1'b0;
        end else begin
            Aes_EN   <= 1'b1;
            Ack      <= '0;
            Err      <= 1'b0;
            Aes_Krdy <= 1'b0;
            Aes_Drdy <= 1'b0;
            if (KFlush) begin
                key_vld <= 1'b0;
            end

            case (state)
                StIdle: begin
                    // Holding off while the core is busy keeps strobes away from BSY.
                    if (gnt_vld && !Aes_BSY) begin
                        rr_ptr  <= gnt_idx;
                        Gnt_id  <= gnt_idx;
                        Aes_Kin <= sel_key;
                        Aes_Din <= sel_pt;
                        Busy    <= 1'b1;
                        if (key_hit) begin
                            state    <= StDstart;
                            Aes_Drdy <= 1'b1;
                        end else begin
                            state    <= StKload;
                            Aes_Krdy <= 1'b1;
                        end
                    end
                end
                StKload: begin
                    key_cache <= Aes_Kin;
                    key_vld   <= !KFlush;
                    state     <= StKwait;
                end
                StKwait: begin
                    state    <= StDstart;
                    Aes_Drdy <= 1'b1;
                end
                StDstart: begin
                    bsy_seen <= 1'b0;
                    timer    <= '0;
                    state    <= StDbusy;
                end
                StDbusy: begin
                    if (Aes_BSY) begin
                        bsy_seen <= 1'b1;
                    end
                    if (job_done) begin
                        state <= StDone;
                        Dout  <= Aes_Dout;
                        for (int i = 0; i < int'(NREQ); i++) begin
                            Ack[i] <= (Gnt_id == GNT_W'(i));
                        end
                    end else if (timeout_hit) begin
                        Err     <= 1'b1;
                        key_vld <= 1'b0;
                        Busy    <= 1'b0;
                        state   <= StIdle;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                StDone: begin
                    Busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_scheduler.sv
// Self-checking bench for aes_enc_scheduler with a behavioural AES core model.
module tb_aes_enc_scheduler;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 32;

    logic                  CLK = 1'b0;
    logic                  RSTn;
    logic [NREQ-1:0]       Req;
    logic [NREQ*128-1:0]   Kreq;
    logic [NREQ*128-1:0]   Dreq;
    logic                  KFlush;
    logic [NREQ-1:0]       Ack;
    logic [127:0]          Dout;
    logic                  Err;
    logic [2:0]            Gnt_id;
    logic                  Busy;
    logic [127:0]          Aes_Kin;
    logic [127:0]          Aes_Din;
    logic                  Aes_Krdy;
    logic                  Aes_Drdy;
    logic                  Aes_EN;
    logic [127:0]          Aes_Dout;
    logic                  Aes_BSY;
    logic                  Aes_Dvld;

    aes_enc_scheduler #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .Req      (Req),
        .Kreq     (Kreq),
        .Dreq     (Dreq),
        .KFlush   (KFlush),
        .Ack      (Ack),
        .Dout     (Dout),
        .Err      (Err),
        .Gnt_id   (Gnt_id),
        .Busy     (Busy),
        .Aes_Kin  (Aes_Kin),
        .Aes_Din  (Aes_Din),
        .Aes_Krdy (Aes_Krdy),
        .Aes_Drdy (Aes_Drdy),
        .Aes_EN   (Aes_EN),
        .Aes_Dout (Aes_Dout),
        .Aes_BSY  (Aes_BSY),
        .Aes_Dvld (Aes_Dvld)
    );

    always #5 CLK = ~CLK;

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   ns [16];
        logic [31:0]  t;
        logic [7:0]   rcon = 8'h01;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) st[i] = sbox[st[i]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) ns[c*4+rw] = st[((c+rw)%4)*4+rw];
            for (int i = 0; i < 16; i++) st[i] = ns[i];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[c*4]; a1 = st[c*4+1]; a2 = st[c*4+2]; a3 = st[c*4+3];
                    st[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    st[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    st[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    st[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[r*4+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // ---------------- AES core model: 10 busy cycles after Drdy ----------------
    logic [127:0] core_key;
    logic [127:0] core_res;
    int           core_cnt;
    logic         stuck;
    int           krdy_cnt;
    int           strobe_viol;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Aes_BSY  <= 1'b0;
            Aes_Dvld <= 1'b0;
            Aes_Dout <= '0;
            core_cnt <= 0;
        end else begin
            if (Aes_Krdy) core_key <= Aes_Kin;
            if (Aes_Drdy) begin
                core_res <= aes_enc(core_key, Aes_Din);
                core_cnt <= 10;
                Aes_BSY  <= 1'b1;
                Aes_Dvld <= 1'b0;
            end else if (Aes_BSY && !stuck) begin
                if (core_cnt == 1) begin
                    Aes_BSY  <= 1'b0;
                    Aes_Dvld <= 1'b1;
                    Aes_Dout <= core_res;
                end
                core_cnt <= core_cnt - 1;
            end
        end
    end

    always @(posedge CLK) begin
        if (Aes_Krdy) krdy_cnt <= krdy_cnt + 1;
        if ((Aes_Krdy || Aes_Drdy) && Aes_BSY) strobe_viol <= strobe_viol + 1;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scheduler model: key cache and round-robin pointer.
    logic         m_vld;
    logic [127:0] m_key;
    int           m_ptr;

    function automatic int m_grant(input logic [NREQ-1:0] rq);
        for (int off = 1; off <= NREQ; off++) begin
            if (rq[(m_ptr + off) % NREQ]) return (m_ptr + off) % NREQ;
        end
        return -1;
    endfunction

    // Counts cycles from the current (grant) cycle until Ack or Err is seen.
    task automatic wait_done(output int lat, output logic [NREQ-1:0] a,
                             output logic [127:0] d, output logic e, output logic [2:0] g);
        logic found = 1'b0;
        lat = -1; a = '0; d = '0; e = 1'b0; g = '0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge CLK);
            if (Ack != '0 || Err) begin
                found = 1'b1;
                lat = n; a = Ack; d = Dout; e = Err; g = Gnt_id;
            end
        end
    endtask

    task automatic run_single(input string tag, input int r, input logic [127:0] k,
                              input logic [127:0] p);
        int               lat;
        int               k0;
        logic [NREQ-1:0]  a;
        logic [127:0]     d;
        logic             e;
        logic [2:0]       g;
        logic             hit;
        hit = m_vld && (m_key == k);
        @(posedge CLK); #1;
        k0 = krdy_cnt;
        Kreq[r*128 +: 128] = k;
        Dreq[r*128 +: 128] = p;
        Req[r] = 1'b1;
        wait_done(lat, a, d, e, g);
        Req[r] = 1'b0;
        chk({tag, "_lat"}, 128'(lat), 128'(hit ? 13 : 15));
        chk({tag, "_ack"}, 128'(a), 128'(1 << r));
        chk({tag, "_dout"}, d, aes_enc(k, p));
        chk({tag, "_gnt"}, 128'(g), 128'(r));
        chk({tag, "_krdy"}, 128'(krdy_cnt - k0), 128'(hit ? 0 : 1));
        m_ptr = r; m_key = k; m_vld = 1'b1;
    endtask

    logic [127:0] fk, fp, rk, rp;
    logic [127:0] jk [NREQ];
    logic [127:0] jp [NREQ];
    int           lat;
    logic [NREQ-1:0] a;
    logic [127:0] d;
    logic         e;
    logic [2:0]   g;
    int           exp_id;
    int           id;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rl(inv) ^ rl(rl(inv)) ^ rl(rl(rl(inv))) ^ rl(rl(rl(rl(inv)))) ^ 8'h63;
        end
        RSTn = 1'b0; Req = '0; Kreq = '0; Dreq = '0; KFlush = 1'b0; stuck = 1'b0;
        krdy_cnt = 0; strobe_viol = 0;
        m_vld = 1'b0; m_key = '0; m_ptr = NREQ - 1;

        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", 128'(Busy), 128'(0));
        chk("rst_en", 128'(Aes_EN), 128'(0));
        chk("rst_strobes", 128'({Aes_Krdy, Aes_Drdy, Err}), 128'(0));
        @(negedge CLK) RSTn = 1'b1;
        @(posedge CLK); #1;
        chk("en_after_rst", 128'(Aes_EN), 128'(1));
        chk("idle_busy", 128'(Busy), 128'(0));

        // FIPS-197 vector: miss then hit
        fk = 128'h000102030405060708090a0b0c0d0e0f;
        fp = 128'h00112233445566778899aabbccddeeff;
        chk("fips_ref", aes_enc(fk, fp), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        run_single("fips_miss", 0, fk, fp);
        chk("fips_dout", Dout, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        run_single("fips_hit", 0, fk, fp);

        // Randomized single jobs with frequent key reuse
        for (int i = 0; i < 8; i++) begin
            rk = ($urandom_range(0, 1) == 0) ? m_key : {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            run_single("rnd", $urandom_range(0, NREQ - 1), rk, rp);
        end

        // Both requesters held: alternating grants
        @(posedge CLK); #1;
        for (int r = 0; r < NREQ; r++) begin
            jk[r] = {$urandom, $urandom, $urandom, $urandom};
            jp[r] = {$urandom, $urandom, $urandom, $urandom};
            Kreq[r*128 +: 128] = jk[r];
            Dreq[r*128 +: 128] = jp[r];
        end
        Req = '1;
        for (int j = 0; j < 4; j++) begin
            exp_id = m_grant(Req);
            wait_done(lat, a, d, e, g);
            id = (a == 2'b10) ? 1 : 0;
            chk("pair_ack", 128'(a), 128'(1 << exp_id));
            chk("pair_dout", d, aes_enc(jk[exp_id], jp[exp_id]));
            m_ptr = exp_id; m_key = jk[exp_id]; m_vld = 1'b1;
            if (j == 3) begin
                Req = '0;
            end else begin
                jk[id] = {$urandom, $urandom, $urandom, $urandom};
                jp[id] = {$urandom, $urandom, $urandom, $urandom};
                Kreq[id*128 +: 128] = jk[id];
                Dreq[id*128 +: 128] = jp[id];
            end
        end

        // Flush between two identical jobs
        run_single("pre_flush", 1, fk, fp);
        @(posedge CLK); #1 KFlush = 1'b1;
        @(posedge CLK); #1 KFlush = 1'b0;
        m_vld = 1'b0;
        run_single("post_flush", 1, fk, fp);

        // Core stuck busy: timeout abort on a cached key
        stuck = 1'b1;
        @(posedge CLK); #1;
        Req[1] = 1'b1;
        wait_done(lat, a, d, e, g);
        Req[1] = 1'b0;
        chk("tmo_lat", 128'(lat), 128'(1 + TIMEOUT + 1));
        chk("tmo_err", 128'(e), 128'(1));
        chk("tmo_noack", 128'(a), 128'(0));
        @(negedge CLK);
        chk("tmo_err_pulse", 128'(Err), 128'(0));
        m_ptr = 1; m_vld = 1'b0;
        stuck = 1'b0;
        repeat (15) @(posedge CLK);
        run_single("after_tmo", 1, fk, fp);

        // Asynchronous reset in the middle of a job
        @(posedge CLK); #1;
        Req[0] = 1'b1;
        repeat (6) @(negedge CLK);
        chk("mid_busy", 128'(Busy), 128'(1));
        #2 RSTn = 1'b0;
        #1;
        Req = '0;
        chk("ar_busy", 128'(Busy), 128'(0));
        chk("ar_dout", Dout, 128'(0));
        chk("ar_ack_err", 128'({Ack, Err}), 128'(0));
        chk("ar_gnt", 128'(Gnt_id), 128'(0));
        chk("ar_core", 128'({Aes_Krdy, Aes_Drdy, Aes_EN}), 128'(0));
        @(negedge CLK) RSTn = 1'b1;
        m_vld = 1'b0; m_ptr = NREQ - 1;
        @(negedge CLK);
        chk("ar_idle", 128'(Busy), 128'(0));
        run_single("after_rst", 0, fk, fp);

        chk("strobe_vs_bsy", 128'(strobe_viol), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
